softmax_norm_stream: RTL and testbench

//  Parametrised softmax normaliser. Sits after the per-lane exp stage and takes LANES exp values per beat.

---
 rtl/softmax_norm_stream_if.sv | 30 +++
 rtl/softmax_norm_stream.sv | 176 +++++++++++++++++
 tb/tb_softmax_norm_stream.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_norm_stream_if.sv
// Stream and status bundle of the softmax normaliser: input beats, output
// probability beats, and the running-sum / busy status.
interface softmax_norm_stream_if #(
  parameter int LANES = 32,
  parameter int WORDS = 16,
  parameter int DW    = 16,
  parameter int OW    = 16
);
  localparam int SW = DW + $clog2(LANES * WORDS);

  logic [LANES*DW-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*OW-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic [SW-1:0]       sum_out;
  logic                busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, sum_out, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, sum_out, busy
  );
endinterface

// File: rtl/softmax_norm_stream.sv
// Softmax normaliser: buffers one vector of exp values, sums it, forms
// R = 2^(OW+RB)/S with a restoring divider, then streams x*R/2^RB out.
module softmax_norm_stream #(
  parameter int LANES = 32,
  parameter int WORDS = 16,
  parameter int DW    = 16,
  parameter int OW    = 16,
  parameter int RB    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  softmax_norm_stream_if.slave  bus
);
  localparam int SW = DW + $clog2(LANES * WORDS);
  localparam int QW = OW + RB + 1;
  localparam int PW = DW + QW;
  localparam int TW = PW - RB;
  localparam int BW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW = $clog2(QW);
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);
  localparam logic [CW-1:0] LAST_DIV  = CW'(QW - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_DIV, ST_DRAIN} state_t;
  state_t state_q, state_d;

  logic [LANES*DW-1:0] buf_mem [WORDS];
  logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [BW-1:0]       rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]       div_cnt_q, div_cnt_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [SW-1:0]       rem_q, rem_d;
  logic [QW-1:0]       quo_q, quo_d;
  logic [LANES*OW-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                loaded_q, loaded_d;

  logic                in_ready, busy, load_en;
  logic                in_fire, last_in, out_fire;
  logic [SW-1:0]       beat_sum;
  logic [SW:0]         rem_shift;
  logic [LANES*DW-1:0] rd_word;
  logic [LANES*OW-1:0] scaled;

  assign in_fire  = in_ready & bus.in_valid;
  assign last_in  = in_fire & (beat_cnt_q == LAST_BEAT);
  assign out_fire = out_valid_q & bus.out_ready;
  assign rd_word  = buf_mem[rd_cnt_q];

  // Lane adder tree; the synthesiser balances the chain.
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      beat_sum = beat_sum + SW'(bus.in_data[k*DW +: DW]);
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [PW-1:0] prod;
    logic [TW-1:0] shifted;
    assign prod    = PW'(rd_word[gi*DW +: DW]) * PW'(quo_q);
    assign shifted = TW'(prod >> RB);
    assign scaled[gi*OW +: OW] = (|shifted[TW-1:OW]) ? {OW{1'b1}} : shifted[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_mem[beat_cnt_q] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (last_in) state_d = (sum_d == '0) ? ST_DRAIN : ST_DIV;
      ST_DIV:   if (div_cnt_q == LAST_DIV) state_d = ST_DRAIN;
      ST_DRAIN: if (out_fire && out_last_q) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_LOAD);
    busy     = (state_q == ST_DIV) || (state_q == ST_DRAIN);
    load_en  = (state_q == ST_DRAIN) && !loaded_q && (!out_valid_q || bus.out_ready);
  end

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    sum_d       = sum_q;
    div_cnt_d   = div_cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    rd_cnt_d    = rd_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    loaded_d    = loaded_q;
    // The dividend 2^(OW+RB) is a single leading one, so its bit stream is cnt==0.
    rem_shift   = {rem_q, div_cnt_q == '0};

    if (in_fire) begin
      sum_d      = ((beat_cnt_q == '0) ? '0 : sum_q) + beat_sum;
      beat_cnt_d = last_in ? '0 : beat_cnt_q + BW'(1);
      if (last_in) begin
        div_cnt_d = '0;
        rem_d     = '0;
        quo_d     = '0;
      end
    end

    if (state_q == ST_DIV) begin
      if (rem_shift >= {1'b0, sum_q}) begin
        rem_d = SW'(rem_shift - {1'b0, sum_q});
        quo_d = {quo_q[QW-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[SW-1:0];
        quo_d = {quo_q[QW-2:0], 1'b0};
      end
      div_cnt_d = (div_cnt_q == LAST_DIV) ? '0 : div_cnt_q + CW'(1);
    end

    if (out_fire && out_last_q) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      loaded_d    = 1'b0;
    end else if (load_en) begin
      out_data_d  = scaled;
      out_valid_d = 1'b1;
      out_last_d  = (rd_cnt_q == LAST_BEAT);
      loaded_d    = (rd_cnt_q == LAST_BEAT);
      rd_cnt_d    = (rd_cnt_q == LAST_BEAT) ? '0 : rd_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      div_cnt_q   <= '0;
      sum_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      div_cnt_q   <= div_cnt_d;
      sum_q       <= sum_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      loaded_q    <= loaded_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.sum_out   = sum_q;
endmodule

// File: tb/tb_softmax_norm_stream.sv
// Scoreboard bench for softmax_norm_stream: directed vectors push hand-computed
// beats into a queue; a negedge monitor pops and compares every accepted beat.
`timescale 1ns/1ps
module tb_softmax_norm_stream;
  localparam int LANES = 32;
  localparam int WORDS = 16;
  localparam int DW    = 16;
  localparam int OW    = 16;
  localparam int RB    = 16;
  localparam int SW    = DW + $clog2(LANES * WORDS);
  localparam int QW    = OW + RB + 1;

  typedef logic [LANES*DW-1:0] ibeat_t;
  typedef logic [LANES*OW-1:0] obeat_t;
  typedef struct {
    obeat_t        data;
    logic          last;
    logic [SW-1:0] sum;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     t_last = 0;
  int     rdy_mode = 0;
  exp_t   exp_q[$];
  ibeat_t vin  [WORDS];
  obeat_t vexp [WORDS];

  softmax_norm_stream_if #(.LANES(LANES), .WORDS(WORDS), .DW(DW), .OW(OW)) bus ();

  softmax_norm_stream #(
    .LANES(LANES), .WORDS(WORDS), .DW(DW), .OW(OW), .RB(RB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input obeat_t act, input obeat_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fill(input int in_val, input int out_val);
    for (int w = 0; w < WORDS; w++) begin
      for (int l = 0; l < LANES; l++) begin
        vin[w][l*DW +: DW]  = DW'(in_val);
        vexp[w][l*OW +: OW] = OW'(out_val);
      end
    end
  endtask

  task automatic poke(input int w, input int l, input int in_val, input int out_val);
    vin[w][l*DW +: DW]  = DW'(in_val);
    vexp[w][l*OW +: OW] = OW'(out_val);
  endtask

  task automatic push_exp(input logic [SW-1:0] s);
    exp_t e;
    for (int w = 0; w < WORDS; w++) begin
      e.data = vexp[w];
      e.last = (w == WORDS - 1);
      e.sum  = s;
      exp_q.push_back(e);
    end
  endtask

  // Returns at posedge+1 of cycle t+2, t being the last-beat acceptance cycle.
  task automatic send_vector(input bit hold, input logic [SW-1:0] exp_s);
    for (int w = 0; w < WORDS; w++) begin
      int n;
      n = 0;
      bus.in_data  = vin[w];
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (!bus.in_ready) begin
        checks++;
        failures++;
        $display("FAIL in_ready_timeout: got in_ready=0 at beat %0d, required 1", w);
      end
      t_last = cyc;
      @(posedge clk);
      #1;
    end
    if (!hold) bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sum_out_final", obeat_t'(bus.sum_out), obeat_t'(exp_s));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_first_valid(input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 200);
    chk("first_valid_latency", obeat_t'(cyc - t_last), obeat_t'(exp_lat));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("beats_remaining", obeat_t'(exp_q.size()), '0);
    exp_q.delete();
    @(negedge clk);
    chk("in_ready_after_drain", obeat_t'(bus.in_ready), obeat_t'(1));
    chk("out_valid_after_drain", obeat_t'(bus.out_valid), '0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", obeat_t'(bus.out_valid), '0);
    chk("rst_out_last", obeat_t'(bus.out_last), '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_sum_out", obeat_t'(bus.sum_out), '0);
    chk("rst_busy", obeat_t'(bus.busy), '0);
    chk("rst_in_ready", obeat_t'(bus.in_ready), obeat_t'(1));
  endtask

  initial begin
    int ph;
    ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        bus.out_ready = 1'b1;
      end else begin
        bus.out_ready = (ph == 0);
        ph = (ph == 2) ? 0 : ph + 1;
      end
    end
  end

  // Monitor: compares accepted beats against the queue and checks stalled beats hold.
  initial begin
    logic   stall_p;
    logic   stall_l;
    obeat_t stall_d;
    exp_t   e;
    stall_p = 1'b0;
    stall_l = 1'b0;
    stall_d = '0;
    forever begin
      @(negedge clk);
      if (stall_p) begin
        chk("stall_valid", obeat_t'(bus.out_valid), obeat_t'(1));
        chk("stall_data", bus.out_data, stall_d);
        chk("stall_last", obeat_t'(bus.out_last), obeat_t'(stall_l));
      end
      stall_p = bus.out_valid && !bus.out_ready && rst;
      stall_d = bus.out_data;
      stall_l = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data %0h, required no beat", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_last", obeat_t'(bus.out_last), obeat_t'(e.last));
          chk("sum_out_drain", obeat_t'(bus.sum_out), obeat_t'(e.sum));
          chk("in_ready_drain", obeat_t'(bus.in_ready), '0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish within 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1;

    // 1: all ones -> S=512, R=2^23, every lane 128
    fill(1, 128);
    push_exp(512);
    send_vector(1'b0, 512);
    wait_first_valid(QW + 2);
    wait_drain();

    // 2: single 100 -> S=100, R=42949672, that lane 65535
    fill(0, 0);
    poke(5, 7, 100, 65535);
    push_exp(100);
    send_vector(1'b0, 100);
    wait_first_valid(QW + 2);
    wait_drain();

    // 3: all zeros -> divider skipped
    fill(0, 0);
    push_exp(0);
    send_vector(1'b0, 0);
    wait_first_valid(2);
    wait_drain();

    // 4: test 1 with out_ready 1-on/2-off
    rdy_mode = 1;
    fill(1, 128);
    push_exp(512);
    send_vector(1'b0, 512);
    wait_first_valid(QW + 2);
    wait_drain();
    rdy_mode = 0;

    // 5: reset mid-divide, then a fresh all-ones vector
    fill(1, 128);
    send_vector(1'b0, 512);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("busy_in_div", obeat_t'(bus.busy), obeat_t'(1));
    chk("in_ready_in_div", obeat_t'(bus.in_ready), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state();
    repeat (40) @(posedge clk);
    #1;
    push_exp(512);
    send_vector(1'b0, 512);
    wait_first_valid(QW + 2);
    wait_drain();

    // 6: back-to-back, in_valid held: all 3s (S=1536 -> 127), then S=4 vector
    fill(3, 127);
    push_exp(1536);
    send_vector(1'b1, 1536);
    fill(0, 0);
    poke(0, 0, 1, 16384);
    poke(0, 1, 3, 49152);
    push_exp(4);
    send_vector(1'b0, 4);
    wait_drain();

    // 7: S=1 -> R=2^32, x*R/2^RB = 65536 saturates to 65535
    fill(0, 0);
    poke(15, 31, 1, 65535);
    push_exp(1);
    send_vector(1'b0, 1);
    wait_first_valid(QW + 2);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
